// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache (8 x 128-bit lines) with a single-block refill FSM.
// Optional hit/miss statistics ports are built when ICACHE_STATS_EN is defined.
module instruction_cache_controller (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  // Fetch handshake: the IF stage raises read with a stable address; the fetch
  // completes on the rising edge where busywait is low, and address/read are
  // held stable for as long as busywait is high.
  state_t state;
  state_t next_state;

  logic [127:0] data_mem [8];
  logic [2:0]   tag_mem  [8];
  logic [7:0]   valid_mem;

  logic [5:0]   fill_addr;
  logic [127:0] fill_block;
  logic         mem_seen;

  logic [2:0]   addr_tag;
  logic [2:0]   addr_index;
  logic [1:0]   addr_word;
  logic         hit;
  logic [127:0] line;
  logic [31:0]  word_sel;
  logic         unused_byte_bits;

  assign addr_tag         = address[9:7];
  assign addr_index       = address[6:4];
  assign addr_word        = address[3:2];
  assign unused_byte_bits = ^address[1:0];

  assign hit  = valid_mem[addr_index] && (tag_mem[addr_index] == addr_tag);
  assign line = data_mem[addr_index];

  always_comb begin
    word_sel = line[31:0];
    case (addr_word)
      2'd0: word_sel = line[31:0];
      2'd1: word_sel = line[63:32];
      2'd2: word_sel = line[95:64];
      2'd3: word_sel = line[127:96];
      default: word_sel = line[31:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // The first MEM_READ edge is ignored so memory has sampled mem_read before
  // a low mem_busywait is trusted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (read && !hit)             next_state = MEM_READ;
      MEM_READ: if (mem_seen && !mem_busywait) next_state = UPDATE;
      UPDATE:                                  next_state = IDLE;
      default:                                 next_state = IDLE;
    endcase
  end

  always_comb begin
    busywait    = 1'b0;
    mem_read    = 1'b0;
    instruction = 32'd0;
    mem_address = fill_addr;
    if (reset) begin
      busywait = (state != IDLE) || (read && !hit);
      mem_read = (state == MEM_READ);
      if (state == IDLE && read && hit) instruction = word_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_mem <= 8'd0;
      fill_addr <= 6'd0;
      mem_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_seen <= 1'b0;
          if (read && !hit) fill_addr <= {addr_tag, addr_index};
        end
        MEM_READ: mem_seen <= 1'b1;
        UPDATE:   valid_mem[fill_addr[2:0]] <= 1'b1;
        default:  mem_seen <= 1'b0;
      endcase
    end
  end

  // Line data and tags are qualified by valid, so they carry no reset.
  always_ff @(posedge clock) begin
    if (reset && state == MEM_READ && mem_seen && !mem_busywait)
      fill_block <= mem_readinst;
    if (reset && state == UPDATE) begin
      data_mem[fill_addr[2:0]] <= fill_block;
      tag_mem[fill_addr[2:0]]  <= fill_addr[5:3];
    end
  end

`ifdef ICACHE_STATS_EN
  logic after_update;

  always_ff @(posedge clock) begin
    if (!reset) begin
      after_update <= 1'b0;
      hit_count    <= 16'd0;
      miss_count   <= 16'd0;
    end else begin
      after_update <= (state == UPDATE);
      // The replay lookup right after a fill is part of the miss, not a hit.
      if (state == IDLE && read && hit && !after_update && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (state == IDLE && next_state == MEM_READ && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/instruction_cache_controller.md
# instruction_cache_controller

Direct-mapped instruction cache and fill controller between the fetch stage and `instruction_memory`. It serves 32-bit instruction fetches from an 8-line store of 128-bit blocks and, on a miss, issues one block read to instruction memory, holding the fetch stage stalled until the line is filled. It is the only requester that drives `instruction_memory`.

## Interface
Parameters (fixed geometry, no parameters exposed):
- none. The geometry is 8 lines × 128 bits, a 3-bit tag, a 3-bit index and a 2-bit word offset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- read  in  1  fetch request from the IF stage
- address  in  10  fetch byte address; bits [1:0] are ignored, [3:2] word, [6:4] index, [9:7] tag
- instruction  out  32  fetched instruction; valid when `read`=1 and `busywait`=0
- busywait  out  1  stall to the IF stage
- mem_read  out  1  block read request to `instruction_memory.read`
- mem_address  out  6  block address {tag,index} to `instruction_memory.address`
- mem_readinst  in  128  block data from `instruction_memory.readinst`
- mem_busywait  in  1  `instruction_memory.busywait`
- hit_count, miss_count  out  16 each  present only with `ICACHE_STATS_EN` (see Configuration)

## Operation
- Storage: `data[8]` is 128 bits, `tag[8]` is 3 bits, `valid[8]` is 1 bit. Only `valid` is reset.
- Word select: offset 0 selects bits [31:0], 1 selects [63:32], 2 selects [95:64], 3 selects [127:96].
- Hit: `valid[index]` && `tag[index]`==address[9:7]. The hit is computed combinationally from `address`.
- The FSM has three states: IDLE, MEM_READ and UPDATE.
  - IDLE:
    - On `read` with a hit, `instruction` is the selected word and `busywait`=0.
    - On `read` with a miss, `busywait`=1 in the same cycle. The controller latches {tag,index} and moves to MEM_READ.
    - With `read`=0, `busywait`=0 and the state is held.
  - MEM_READ:
    - `mem_read`=1 and `mem_address` is the latched {tag,index}.
    - When an edge samples `mem_busywait`=0 while `mem_read` is already high, the controller captures `mem_readinst` and moves to UPDATE.
  - UPDATE:
    - `mem_read`=0.
    - The controller writes data, tag and `valid`=1 into the latched index, then returns to IDLE.
    - In IDLE the lookup is replayed and now hits.
- `busywait` = (IDLE && `read` && !hit) || state≠IDLE.
- The IF stage holds `address` and `read` stable while `busywait`=1. A refill that has started always completes, even if `read` drops.
- A miss replaces the line unconditionally. Instruction memory is read-only, so there is no write-back.

## Timing
- Reset (edge with `reset`=0): state goes to IDLE, all `valid` bits are cleared, and `mem_read`=0, `mem_address`=0 and the counters are 0. During reset `busywait`=0 and `instruction`=0.
- Hit latency is 0 cycles (combinational read). The fetch completes on the edge where `busywait`=0.
- Miss penalty is 2 + N cycles, where N is the number of MEM_READ cycles (memory latency). The sequence is:
  - cycle 0: lookup miss
  - cycles 1..N: MEM_READ
  - cycle N+1: UPDATE
  - cycle N+2: hit
- `mem_read` is asserted starting at the first MEM_READ cycle. It is deasserted on the edge that enters UPDATE and never glitches inside MEM_READ.
- The controller ignores `mem_busywait` on the first MEM_READ edge, so that memory has seen `mem_read` before the controller trusts a low `busywait`.
- Reset asserted mid-refill: the controller returns to IDLE, drops `mem_read`, discards the block and leaves the line invalid. Memory is reset in the same cycle.
- Back-to-back misses to different lines are serviced one at a time, with no overlap.
- Lookups with the same index but a different tag thrash. Each of them misses.

## Configuration
- `ICACHE_STATS_EN` defined: the `hit_count` and `miss_count` ports exist.
  - `miss_count` increments on each IDLE→MEM_READ transition.
  - `hit_count` increments on each IDLE edge with `read`&&hit, excluding the replay edge immediately after UPDATE.
  - Both counters saturate at 0xFFFF and are cleared by reset.
- `ICACHE_STATS_EN` undefined: the ports, counters and logic are absent. Cache behaviour is identical in both cases.

## Test plan
- Reset, then fetch address 0x000 with memory block 0 = 0x33333333_22222222_11111111_00000000. Required:
  - `busywait` goes high the same cycle.
  - `mem_read`=1 with `mem_address`=0.
  - After the fill, `instruction`=0x00000000 with `busywait`=0.
- Fetch 0x004, 0x008 and 0x00C after that fill. Required: each hits with 0 stall, returns 0x11111111, 0x22222222 and 0x33333333 respectively, and `mem_read` stays 0.
- Fetch 0x010 (block 1), then 0x090 (block 9, same index 1). Required:
  - Both miss, with `mem_address` 0x01 then 0x09.
  - A following 0x010 misses again.
  - With stats enabled, `miss_count`=3.
- Memory latency N=3 on a miss. Required:
  - `busywait` high for exactly 5 cycles.
  - `mem_read` high for exactly 3 cycles.
  - Data is captured only on the low `mem_busywait` edge.
- Assert `reset`=0 during MEM_READ for 0x020, then fetch 0x020 again. Required: the first fetch leaves the line invalid, and the second fetch performs a full refill with `mem_address`=0x02.
- Stats enabled: apply 1 miss followed by 4 hits to the same line. Required: `hit_count`=4 and `miss_count`=1, with the replay edge not counted.
